// File: rtl/ahb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : ahb_pkg                                                          |
// | Purpose : AHB-Lite bus encodings shared by masters and slaves              |
// |           (HTRANS, HBURST, HSIZE, HRESP, data bus width).                  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package ahb_pkg;

  localparam int HDATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ahb_slave_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : ahb_slave_mem_pkg                                                |
// | Purpose : Responder FSM state encoding and byte-lane decode helper for     |
// |           ahb_slave_mem.                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package ahb_slave_mem_pkg;
  import ahb_pkg::*;

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ERR1  = 2'd2;
  localparam logic [1:0] ST_ERR2  = 2'd3;

  // Little-endian lane enables: byte lane = addr[1:0], halfword pair
  // starts at {addr[1],0}, word uses all four lanes.
  function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                           input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << addr_lo;
      HSIZE_HALF: m = 4'b0011 << {addr_lo[1], 1'b0};
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_slave_mem_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : ahb_slave_mem_if                                               |
// | Purpose   : AHB-Lite signal bundle for one HSEL slot.                      |
// |   master modport drives HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA/HREADY|
// |   slave  modport drives HRDATA/HREADYOUT/HRESP                             |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface ahb_slave_mem_if;
  import ahb_pkg::*;

  logic               HSEL;
  logic [31:0]        HADDR;
  logic [1:0]         HTRANS;
  logic               HWRITE;
  logic [2:0]         HSIZE;
  logic [2:0]         HBURST;
  logic [HDATA_W-1:0] HWDATA;
  logic               HREADY;
  logic [HDATA_W-1:0] HRDATA;
  logic               HREADYOUT;
  logic               HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

endinterface
`default_nettype wire

// File: rtl/ahb_slave_mem_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ahb_slave_mem_array                                              |
// | Purpose : 2^WORD_AW x 32 word RAM, per-byte write enable, synchronous      |
// |           write, combinational read. Contents are not reset.               |
// | Ports   : clk      clock                                                   |
// |           i_we     byte write enables (lane i -> bits [8i+7:8i])           |
// |           i_waddr  write word index      i_wdata  write data              |
// |           i_raddr  read word index       o_rdata  read data (comb)        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ahb_slave_mem_array #(
  parameter int WORD_AW = 8
) (
  input  wire logic               clk,
  input  wire logic [3:0]         i_we,
  input  wire logic [WORD_AW-1:0] i_waddr,
  input  wire logic [31:0]        i_wdata,
  input  wire logic [WORD_AW-1:0] i_raddr,
  output logic      [31:0]        o_rdata
);

  localparam int DEPTH = 1 << WORD_AW;

  logic [31:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/ahb_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ahb_slave_mem                                                    |
// | Purpose : AHB-Lite responder backed by a word-organised memory. Handles    |
// |           byte/halfword/word transfers, programmable wait states, and the  |
// |           two-cycle ERROR response for illegal accesses.                   |
// | Ports   : HCLK     clock (rising edge)                                     |
// |           HRESETn  asynchronous active-low reset                           |
// |           ahb      slave modport: HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/    |
// |                    HWDATA/HREADY in; HRDATA/HREADYOUT/HRESP out            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ahb_slave_mem #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  wire logic     HCLK,
  input  wire logic     HRESETn,
  ahb_slave_mem_if.slave ahb
);
  import ahb_pkg::*;
  import ahb_slave_mem_pkg::*;

  localparam int         WORD_AW     = ADDR_WIDTH - 2;
  localparam logic [3:0] c_wait_init = 4'(WAIT_STATES);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [3:0]         r_cnt;
  logic               w_hreadyout;
  logic               w_hresp;
  logic               w_accept;
  logic               w_err;
  logic               w_okay_accept;
  logic               w_commit;
  logic               r_dp_wr;
  logic [WORD_AW-1:0] r_dp_addr;
  logic [WORD_AW-1:0] w_raddr;
  logic [3:0]         r_dp_lanes;
  logic [3:0]         w_lanes;
  logic [3:0]         w_we;
  logic [31:0]        w_mem_rdata;
  logic [31:0]        w_rdata_next;
  logic [31:0]        r_hrdata;
  logic               w_unused;

  // HBURST is informational; HTRANS[0] only distinguishes SEQ from NONSEQ.
  assign w_unused = ^{ahb.HBURST, ahb.HTRANS[0]};

  // Address phase handshake and legality check
  assign w_accept = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] & w_hreadyout;
  assign w_err    = (ahb.HSIZE > HSIZE_WORD)
                  | ((ahb.HSIZE == HSIZE_HALF) & ahb.HADDR[0])
                  | ((ahb.HSIZE == HSIZE_WORD) & (ahb.HADDR[1:0] != 2'b00))
                  | (ahb.HADDR[31:ADDR_WIDTH] != '0);
  assign w_okay_accept = w_accept & ~w_err;
  assign w_lanes       = lane_mask(ahb.HSIZE, ahb.HADDR[1:0]);
  assign w_raddr       = ahb.HADDR[ADDR_WIDTH-1:2];

  // A pending write retires on the edge that ends its data phase.
  assign w_commit = r_dp_wr & w_hreadyout;
  assign w_we     = w_commit ? r_dp_lanes : 4'b0000;

  ahb_slave_mem_array #(
    .WORD_AW (WORD_AW)
  ) u_array (
    .clk     (HCLK),
    .i_we    (w_we),
    .i_waddr (r_dp_addr),
    .i_wdata (ahb.HWDATA),
    .i_raddr (w_raddr),
    .o_rdata (w_mem_rdata)
  );

  // The array updates only after this edge, so a read landing on the word
  // being written takes the written lanes straight from HWDATA.
  always_comb begin
    w_rdata_next = w_mem_rdata;
    if (w_commit && (r_dp_addr == w_raddr)) begin
      for (int i = 0; i < 4; i++) begin
        if (r_dp_lanes[i]) w_rdata_next[8*i +: 8] = ahb.HWDATA[8*i +: 8];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= ST_READY;
    else          r_state <= w_next_state;
  end

  // FSM: next state. ERR2 ends a data phase, so it can take a new address.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_READY, ST_ERR2: begin
        w_next_state = ST_READY;
        if (w_accept) begin
          if (w_err)                w_next_state = ST_ERR1;
          else if (WAIT_STATES > 0) w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: if (r_cnt <= 4'd1) w_next_state = ST_READY;
      ST_ERR1: w_next_state = ST_ERR2;
      default: w_next_state = ST_READY;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_hreadyout = 1'b1;
    w_hresp     = HRESP_OKAY;
    case (r_state)
      ST_WAIT: w_hreadyout = 1'b0;
      ST_ERR1: begin
        w_hreadyout = 1'b0;
        w_hresp     = HRESP_ERROR;
      end
      ST_ERR2: w_hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  // Data-phase registers, wait counter and read data
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_wr    <= 1'b0;
      r_dp_addr  <= '0;
      r_dp_lanes <= 4'b0000;
      r_hrdata   <= '0;
      r_cnt      <= 4'd0;
    end else begin
      if (w_hreadyout) r_dp_wr <= w_okay_accept & ahb.HWRITE;
      if (w_accept) begin
        r_dp_addr  <= w_raddr;
        r_dp_lanes <= w_lanes;
      end
      if (w_okay_accept && !ahb.HWRITE) r_hrdata <= w_rdata_next;
      if (w_okay_accept)              r_cnt <= c_wait_init;
      else if (r_state == ST_WAIT)    r_cnt <= r_cnt - 4'd1;
    end
  end

  assign ahb.HRDATA    = r_hrdata;
  assign ahb.HREADYOUT = w_hreadyout;
  assign ahb.HRESP     = w_hresp;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ahb_slave_mem                                                 |
// | Purpose : Scoreboard bench for ahb_slave_mem. Two instances: dut 0 with    |
// |           zero wait states, dut 1 with two. A byte-level memory model      |
// |           predicts read data; a negedge monitor retires each data phase.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  logic HCLK = 1'b0;
  logic rst_n;
  always #5 HCLK = ~HCLK;

  logic [1:0]       hsel, hwrite, hrdy, hresp;
  logic [1:0][31:0] haddr, hwdata, hrdata;
  logic [1:0][1:0]  htrans;
  logic [1:0][2:0]  hsize, hburst;

  ahb_slave_mem_if bus0 ();
  ahb_slave_mem_if bus1 ();

  assign bus0.HSEL = hsel[0];     assign bus1.HSEL = hsel[1];
  assign bus0.HADDR = haddr[0];   assign bus1.HADDR = haddr[1];
  assign bus0.HTRANS = htrans[0]; assign bus1.HTRANS = htrans[1];
  assign bus0.HWRITE = hwrite[0]; assign bus1.HWRITE = hwrite[1];
  assign bus0.HSIZE = hsize[0];   assign bus1.HSIZE = hsize[1];
  assign bus0.HBURST = hburst[0]; assign bus1.HBURST = hburst[1];
  assign bus0.HWDATA = hwdata[0]; assign bus1.HWDATA = hwdata[1];
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus1.HREADY = bus1.HREADYOUT;
  assign hrdy[0] = bus0.HREADYOUT;  assign hrdy[1] = bus1.HREADYOUT;
  assign hresp[0] = bus0.HRESP;     assign hresp[1] = bus1.HRESP;
  assign hrdata[0] = bus0.HRDATA;   assign hrdata[1] = bus1.HRDATA;

  ahb_slave_mem #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(rst_n), .ahb(bus0));
  ahb_slave_mem #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_dut1 (
    .HCLK(HCLK), .HRESETn(rst_n), .ahb(bus1));

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int          d;
    bit          err;
    bit          rd;
    logic [31:0] rdata;
    int          low;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mdl [2][1024];
  bit         dp_act [2];
  int         lowc [2];
  int         errc [2];

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic bit illegal(input logic [31:0] a, input logic [2:0] sz);
    if (sz > 3'd2) return 1'b1;
    if ((a % (32'd1 << sz)) != 0) return 1'b1;
    return (a >= 32'd1024);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic check_end(input int d);
    exp_t e;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty dut=%0d got=data phase exp=no transfer", d);
      return;
    end
    e = sb_q.pop_front();
    if (e.d != d) begin
      n_err++;
      $display("FAIL sb_order got dut=%0d exp dut=%0d", d, e.d);
    end else if (e.err) begin
      if (errc[d] != 2 || lowc[d] != 1) begin
        n_err++;
        $display("FAIL err_resp dut=%0d got hresp_cycles=%0d low=%0d exp 2/1",
                 d, errc[d], lowc[d]);
      end
    end else if (errc[d] != 0 || lowc[d] != e.low) begin
      n_err++;
      $display("FAIL okay_timing dut=%0d got hresp_cycles=%0d low=%0d exp 0/%0d",
               d, errc[d], lowc[d], e.low);
    end else if (e.rd && hrdata[d] !== e.rdata) begin
      n_err++;
      $display("FAIL rdata dut=%0d got=%08h exp=%08h", d, hrdata[d], e.rdata);
    end
  endtask

  always @(negedge HCLK) begin
    if (!rst_n) begin
      dp_act[0] = 1'b0;
      dp_act[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (dp_act[d]) begin
          if (hresp[d]) errc[d]++;
          if (!hrdy[d]) lowc[d]++;
          else begin
            check_end(d);
            dp_act[d] = 1'b0;
          end
        end
        if (hsel[d] && htrans[d][1] && hrdy[d]) begin
          dp_act[d] = 1'b1;
          lowc[d]   = 0;
          errc[d]   = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Entered at posedge+1; returns at posedge+1 after acceptance with the
  // transfer's write data on HWDATA and the address bus idle.
  task automatic issue(input int d, input logic [31:0] a, input bit wr,
                       input logic [2:0] sz, input logic [31:0] wd,
                       input logic [1:0] tr, input logic [2:0] hb, input bit track);
    int   guard;
    bit   rdy;
    int   b;
    int   base;
    exp_t e;
    hsel[d] = 1'b1; haddr[d] = a; htrans[d] = tr;
    hwrite[d] = wr; hsize[d] = sz; hburst[d] = hb;
    guard = 0;
    do begin
      @(negedge HCLK);
      rdy = hrdy[d];
      @(posedge HCLK);
      guard++;
    end while (!rdy && guard < 40);
    n_chk++;
    if (!rdy) begin
      n_err++;
      $display("FAIL accept_timeout dut=%0d got=no HREADYOUT exp=accept within 40", d);
    end else if (track) begin
      e.d = d; e.err = illegal(a, sz); e.rd = !wr; e.low = ws(d); e.rdata = '0;
      if (!e.err) begin
        base = int'(a) & ~3;
        if (wr) begin
          for (int k = 0; k < (1 << sz); k++) begin
            b = int'(a) + k;
            mdl[d][b] = wd[8*(b % 4) +: 8];
          end
        end else begin
          e.rdata = {mdl[d][base+3], mdl[d][base+2], mdl[d][base+1], mdl[d][base]};
        end
      end
      sb_q.push_back(e);
    end
    #1;
    hwdata[d] = wd;
    hsel[d]   = 1'b0;
    htrans[d] = HTRANS_IDLE;
  endtask

  task automatic idle(input int d, input int n, input bit busy);
    hsel[d] = busy; htrans[d] = busy ? HTRANS_BUSY : HTRANS_IDLE;
    repeat (n) @(posedge HCLK);
    #1;
    hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || dp_act[0] || dp_act[1]) && guard < 40) begin
      @(posedge HCLK);
      guard++;
    end
    #1;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d pending exp=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_out(input int d, input string tag, input logic ro,
                           input logic rs, input logic [31:0] rd);
    n_chk += 3;
    if (hrdy[d] !== ro) begin
      n_err++; $display("FAIL %s_hreadyout dut=%0d got=%b exp=%b", tag, d, hrdy[d], ro);
    end
    if (hresp[d] !== rs) begin
      n_err++; $display("FAIL %s_hresp dut=%0d got=%b exp=%b", tag, d, hresp[d], rs);
    end
    if (hrdata[d] !== rd) begin
      n_err++; $display("FAIL %s_hrdata dut=%0d got=%08h exp=%08h", tag, d, hrdata[d], rd);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    hsel = '0; hwrite = '0; haddr = '0; hwdata = '0;
    htrans = '0; hsize = '0; hburst = '0;
    repeat (3) @(posedge HCLK);
    #1;
    check_out(0, "reset", 1'b1, 1'b0, 32'h0);
    check_out(1, "reset", 1'b1, 1'b0, 32'h0);
    @(negedge HCLK); #2; rst_n = 1'b1;
    @(posedge HCLK); #1;

    // Give every word a known value so later reads never see uninitialised RAM.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 256; w++)
        issue(d, 32'(w * 4), 1'b1, HSIZE_WORD, $urandom, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
      drain();
    end

    // Directed on the zero-wait instance
    issue(0, 32'h10, 1, HSIZE_WORD, 32'hDEADBEEF, HTRANS_NONSEQ, HBURST_SINGLE, 1);
    issue(0, 32'h10, 0, HSIZE_WORD, 32'h0,        HTRANS_NONSEQ, HBURST_SINGLE, 1);
    issue(0, 32'h10, 1, HSIZE_WORD, 32'h11223344, HTRANS_NONSEQ, HBURST_SINGLE, 1);
    idle(0, 2, 0);
    issue(0, 32'h13, 1, HSIZE_BYTE, 32'hAA000000, HTRANS_NONSEQ, HBURST_SINGLE, 1);
    idle(0, 1, 0);
    issue(0, 32'h10, 0, HSIZE_WORD, 32'h0,        HTRANS_NONSEQ, HBURST_SINGLE, 1);
    issue(0, 32'h20, 1, HSIZE_WORD, 32'h0,        HTRANS_NONSEQ, HBURST_SINGLE, 1);
    issue(0, 32'h20, 1, HSIZE_BYTE, 32'h00000055, HTRANS_NONSEQ, HBURST_SINGLE, 1);
    issue(0, 32'h20, 0, HSIZE_BYTE, 32'h0,        HTRANS_NONSEQ, HBURST_SINGLE, 1);
    // Illegal accesses, then confirm the targeted words are untouched
    issue(0, 32'h02,  1, HSIZE_WORD, 32'hFFFFFFFF, HTRANS_NONSEQ, HBURST_SINGLE, 1);
    issue(0, 32'h40,  1, 3'd3,       32'hFFFFFFFF, HTRANS_NONSEQ, HBURST_SINGLE, 1);
    issue(0, 32'h400, 1, HSIZE_WORD, 32'hFFFFFFFF, HTRANS_NONSEQ, HBURST_SINGLE, 1);
    issue(0, 32'h00,  0, HSIZE_WORD, 32'h0,        HTRANS_NONSEQ, HBURST_SINGLE, 1);
    issue(0, 32'h40,  0, HSIZE_WORD, 32'h0,        HTRANS_NONSEQ, HBURST_SINGLE, 1);
    drain();

    // INCR4 read burst on the two-wait instance
    for (int k = 0; k < 4; k++)
      issue(1, 32'(k * 4), 0, HSIZE_WORD, 32'h0,
            (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_INCR4, 1);
    drain();

    // Randomised traffic, one instance at a time
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        int          r;
        logic [2:0]  sz;
        logic [31:0] a;
        r  = $urandom_range(0, 19);
        sz = 3'($urandom_range(0, 2));
        a  = $urandom_range(0, 1023) & ~((32'd1 << sz) - 1);
        if (r == 0) idle(d, $urandom_range(1, 2), 0);
        else if (r == 1) idle(d, 1, 1);
        else if (r == 2) sz = 3'($urandom_range(3, 7));
        else if (r == 3) begin sz = HSIZE_WORD; a = a | 32'($urandom_range(1, 3)); end
        else if (r == 4) a = a | (32'd1 << $urandom_range(10, 31));
        issue(d, a, $urandom_range(0, 1) == 1, sz, $urandom,
              ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ, HBURST_INCR, 1);
      end
      drain();
    end

    // Reset during a wait state: abandoned write must not reach memory
    issue(1, 32'h80, 1, HSIZE_WORD, 32'hCAFEF00D, HTRANS_NONSEQ, HBURST_SINGLE, 0);
    @(negedge HCLK);
    n_chk++;
    if (hrdy[1] !== 1'b0) begin
      n_err++; $display("FAIL in_wait dut=1 got=%b exp=0", hrdy[1]);
    end
    #2; rst_n = 1'b0;
    #1;
    check_out(1, "async_reset", 1'b1, 1'b0, 32'h0);
    repeat (2) @(negedge HCLK);
    #2; rst_n = 1'b1;
    @(posedge HCLK); #1;
    issue(1, 32'h80, 0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, HBURST_SINGLE, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB-Lite responder with an internal word-organised memory; the target end of the bus driven by the team's AHB master. Accepts single and burst transfers (NONSEQ/SEQ, BUSY tolerated) and performs byte/halfword/word writes with per-lane enables. Returns registered read data, inserts a programmable number of wait states, and signals ERROR with the two-cycle AHB response for illegal accesses. Sits behind the address decoder as one HSEL slot.

## Interface
- ADDR_WIDTH, 10: byte-address bits decoded locally; memory holds 2^(ADDR_WIDTH-2) 32-bit words.
- WAIT_STATES, 0: wait cycles (HREADYOUT low) inserted per OKAY transfer; range 0..15.
- HCLK  in  1  clock; all state changes on rising edge.
- HRESETn  in  1  reset; one clock; reset is asynchronous and active-low.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  byte address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 byte, 1 halfword, 2 word; 3..7 illegal.
- HBURST  in  3  burst type; informational only.
- HWDATA  in  32  write data, valid in data phase.
- HREADY  in  1  bus-level ready (previous transfer complete).
- HRDATA  out  32  read data.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 OKAY, 1 ERROR.

## Operation
- Address phase accepted when HSEL & HREADY & HTRANS[1] at a rising edge; capture addr, write, size into data-phase registers.
- HSEL & HREADY with HTRANS IDLE/BUSY: no access; next data phase is zero-wait OKAY.
- Error checks at acceptance: HSIZE > 2; misalignment (halfword with HADDR[0]=1, word with HADDR[1:0]≠0); HADDR[31:ADDR_WIDTH] ≠ 0. Any -> ERROR response, no memory write.
- Byte lanes little-endian: byte lane = HADDR[1:0]; halfword lanes {HADDR[1],0}+{0,1}; word all four.
- Write: committed at the edge ending the data phase (HREADYOUT=1), using HWDATA lanes only.
- Read: word at captured address loaded into HRDATA at acceptance; held through wait states. Full word returned regardless of HSIZE.
- Read-after-write: if a read is accepted on the same edge a write commits to the same word, HRDATA = memory word with written lanes replaced by HWDATA.
- States: READY, WAIT, ERR1, ERR2.
  - READY: HREADYOUT=1, HRESP=0. Accept OKAY transfer -> WAIT if WAIT_STATES>0 (counter=WAIT_STATES) else stay. Accept erroneous -> ERR1.
  - WAIT: HREADYOUT=0; decrement; counter reaching 1 -> READY.
  - ERR1: HRESP=1, HREADYOUT=0 -> ERR2. ERR2: HRESP=1, HREADYOUT=1 -> READY (may accept new address this edge).
- Errors ignore WAIT_STATES.
- HSEL deasserted: no acceptance; ongoing data phase completes normally.

## Timing
- Reset: HREADYOUT=1, HRESP=0, HRDATA=0, state READY, counter 0, pending data phase cleared. Memory contents not reset.
- Reset mid-transfer: data phase abandoned, pending write dropped, outputs to reset values asynchronously.
- Zero-wait: address at edge N, data phase completes edge N+1; back-to-back transfers every cycle.
- WAIT_STATES=k: data phase spans k+1 cycles; HREADYOUT low exactly k cycles.
- Error: data phase always exactly 2 cycles.
- HRDATA changes only at acceptance of a read; otherwise holds.

## Structure
- Shared package ahb_pkg: HTRANS encodings, HBURST encodings, HSIZE encodings, HRESP_OKAY/HRESP_ERROR, bus width 32.
- Sub-module ahb_slave_mem_array: 2^(ADDR_WIDTH-2) x 32 RAM, 4-bit byte write enable, synchronous write, combinational read port.
- Top holds FSM, wait counter, lane decode, error check, RAW bypass.

## Test plan
- Word write 0xDEADBEEF @0x10 then read @0x10, WAIT_STATES=0 -> HRDATA=0xDEADBEEF in read data phase, HREADYOUT never low.
- Byte write 0xAA @0x13 over 0x11223344 -> read @0x10 gives 0xAA223344.
- Back-to-back write 0x55 byte @0x20 then read @0x20 next cycle (word 0) -> HRDATA=0x00000055 (bypass).
- WAIT_STATES=2, INCR4 reads @0x0 -> each beat HREADYOUT low 2 cycles, addresses 0x0,0x4,0x8,0xC returned in order.
- Word write @0x2 or HSIZE=3 or HADDR=0x400 -> HRESP=1 two cycles, HREADYOUT 0 then 1; memory unchanged.
- Assert HRESETn low during a wait state -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; pending write not committed.
